// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial pattern detector: state encoding,
// reset-time configuration and the window width.
package seq_detect_ctrl_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [W-1:0] RST_PATTERN = 8'h0D;
  localparam logic [2:0]   RST_LEN     = 3'd3;
  localparam logic [W-1:0] RST_TARGET  = 8'd0;

  // len is "length minus one", so len=7 selects all eight bits.
  function automatic logic [W-1:0] len_mask(input logic [2:0] len);
    logic [W:0] m;
    m = (9'd1 << ({1'b0, len} + 4'd1)) - 9'd1;
    return m[W-1:0];
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_pattern_window.sv
// Shift window and fill counter for the detector, plus the masked compare
// of the post-shift window against the configured pattern.
module pattern_window
  import seq_detect_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic [W-1:0] cfg_pattern,
  input  logic [2:0]   cfg_len,
  output logic         filled,
  output logic         match
);

  logic [W-1:0] window_q, window_d;
  logic [3:0]   fill_q, fill_d;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
    end else if (shift_en) begin
      window_d = {window_q[W-2:0], bit_in};
      if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
    end
  end

  // Both flags describe the window as it will be after this shift.
  assign filled = shift_en && (fill_d > {1'b0, cfg_len});
  assign match  = filled && (((window_d ^ cfg_pattern) & len_mask(cfg_len)) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector control: config registers, run FSM and saturating
// match counter around the pattern_window datapath. All outputs registered.
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_pattern,
  input  logic [2:0]   cfg_len,
  input  logic [W-1:0] cfg_target,
  input  logic         start,
  input  logic         abort,
  input  logic         bit_valid,
  input  logic         bit_in,
  output logic         busy,
  output logic         tick,
  output logic [W-1:0] match_count,
  output logic         done,
  output logic         cfg_err,
  output logic [1:0]   state_dbg
);

  state_e       state_q, state_d;
  logic [W-1:0] pattern_q, pattern_d;
  logic [2:0]   len_q, len_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] count_q, count_d, count_inc;
  logic         busy_q, busy_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         win_clear, shift_en, filled, match;

  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  pattern_window u_window (
    .clk         (clk),
    .rst         (rst),
    .clear       (win_clear),
    .shift_en    (shift_en),
    .bit_in      (bit_in),
    .cfg_pattern (pattern_q),
    .cfg_len     (len_q),
    .filled      (filled),
    .match       (match)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    target_d  = target_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    win_clear = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          target_d  = cfg_target;
        end
        if (start) begin
          win_clear = 1'b1;
          count_d   = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL, ST_RUN: begin
        if (cfg_we) err_d = 1'b1;
        // Abort suppresses the shift, so a same-cycle completing bit never ticks.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (filled) state_d = ST_RUN;
          if (match) begin
            tick_d  = 1'b1;
            count_d = count_inc;
            if ((target_q != '0) && (count_inc == target_q)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= RST_PATTERN;
      len_q     <= RST_LEN;
      target_q  <= RST_TARGET;
      count_q   <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      target_q  <= target_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy        = busy_q;
  assign tick        = tick_q;
  assign done        = done_q;
  assign cfg_err     = err_q;
  assign match_count = count_q;
  assign state_dbg   = state_q;

endmodule
